// File: rtl/mulacc_feeder.sv
// Operand feeder for a two-phase multiply-accumulator: a small registered FIFO
// followed by an IDLE/PH0/PH1 issue FSM that presents each operand for two enabled cycles.
module mulacc_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             stall,
    output logic             en,
    output logic [WIDTH-1:0] x,
    output logic             busy,
    output logic [7:0]       issued
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] operand_r;
    logic [7:0]       issued_r;
    logic             push_s;
    logic             pop_s;
    logic             inc_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;

    // FIFO status is derived only from registered occupancy, so no fall-through.
    always_comb begin
        fifo_empty_s = (count_r == {(AW+1){1'b0}});
        fifo_full_s  = (count_r == FULL_COUNT);
        push_s       = in_valid & ~fifo_full_s;
    end

    // Issue FSM next-state logic: pop on IDLE start or PH1 hand-over, count on PH1 exit.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        inc_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && !stall) begin
                    pop_s       = 1'b1;
                    state_nxt_s = PH0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PH0: begin
                if (!stall) begin
                    state_nxt_s = PH1;
                end else begin
                    state_nxt_s = PH0;
                end
            end
            PH1: begin
                if (!stall) begin
                    inc_s = 1'b1;
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = PH0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = PH1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, operand and issue-count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            operand_r <= {WIDTH{1'b0}};
            issued_r  <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if (pop_s) begin
                operand_r <= mem_r[rd_ptr_r];
            end else begin
                operand_r <= operand_r;
            end
            if (inc_s) begin
                issued_r <= issued_r + 8'd1;
            end else begin
                issued_r <= issued_r;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; cleared on reset so no stale operand survives an abandoned run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
            end else begin
                mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
            end
        end
    end

    // Output decode; en must drop within the same cycle as stall.
    always_comb begin
        in_ready = ~fifo_full_s;
        en       = (state_r != IDLE) & ~stall;
        x        = operand_r;
        busy     = (state_r != IDLE) | ~fifo_empty_s;
        issued   = issued_r;
    end

endmodule

// File: tb/tb_mulacc_feeder.sv
// Randomized scoreboard bench for mulacc_feeder: a queue-based reference model predicts
// handshake/status per cycle, and a monitor matches every enabled x against expected operands.
module tb_mulacc_feeder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             stall;
    logic             en;
    logic [WIDTH-1:0] x;
    logic             busy;
    logic [7:0]       issued;

    mulacc_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .stall    (stall),
        .en       (en),
        .x        (x),
        .busy     (busy),
        .issued   (issued)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: operands waiting, the operand being presented, and how many of
    // its two enabled cycles have already happened.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_cur;
    bit               m_active;
    int               m_done_cycles;
    logic [7:0]       m_issued;
    // Scoreboard of x values expected on successive enabled cycles.
    logic [WIDTH-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every enabled cycle consumes one expected x from the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && en === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL x_unexpected: got en=1 x=0x%0h with nothing expected at %0t", x, $time);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (x !== e) begin
                    tests_failed++;
                    $display("FAIL x_order: got 0x%0h expected 0x%0h at %0t", x, e, $time);
                end
            end
        end
    end

    // One clock cycle: drive inputs, check status against the model, advance the model.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit s);
        bit accept;
        in_valid = v;
        in_data  = d;
        stall    = s;
        @(negedge clk);
        chk("in_ready", in_ready, m_q.size() != DEPTH);
        chk("busy", busy, m_active || m_q.size() != 0);
        chk("en", en, m_active && !s);
        chk("issued", issued, m_issued);
        accept = v && (m_q.size() != DEPTH);
        if (!s) begin
            if (m_active && m_done_cycles == 0) begin
                m_done_cycles = 1;
            end else begin
                if (m_active) begin
                    m_issued = m_issued + 8'd1;
                    m_active = 1'b0;
                end
                if (m_q.size() != 0) begin
                    m_cur         = m_q.pop_front();
                    m_active      = 1'b1;
                    m_done_cycles = 0;
                end
            end
        end
        if (accept) begin
            m_q.push_back(d);
            exp_q.push_back(d);
            exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_q.delete();
        exp_q.delete();
        m_active      = 1'b0;
        m_done_cycles = 0;
        m_issued      = 8'd0;
        m_cur         = '0;
    endtask

    // Asynchronous reset pulled mid-cycle; outputs must clear without waiting for an edge.
    task automatic async_reset(input string tag);
        in_valid = 1'b0;
        stall    = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "_en"}, en, 1'b0);
        chk({tag, "_x"}, x, 8'h00);
        chk({tag, "_issued"}, issued, 8'h00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        model_clear();
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_active || m_q.size() != 0); i++) begin
            step(1'b0, 8'h00, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("drain_done", {31'd0, m_active || m_q.size() != 0}, 32'd0);
    endtask

    initial begin
        int accepted;
        int guard;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        stall    = 1'b0;
        model_clear();

        // Reset state while held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_en", en, 1'b0);
        chk("rst_x", x, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_issued", issued, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single operand: en in the 2nd and 3rd cycles after the push cycle.
        step(1'b1, 8'h05, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("single_x_c3", x, 8'h05);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("single_issued", issued, 8'd1);
        chk("single_busy", busy, 1'b0);

        // Fill under stall, overflow push dropped, then back-to-back issue.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1);
        chk("full_in_ready", in_ready, 1'b0);
        step(1'b1, 8'h09, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0);
        chk("fill_issued", issued, 8'd5);

        // Stall during the PH0 cycle of 0x7F.
        step(1'b1, 8'h7F, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("stall_x_held", x, 8'h7F);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        chk("stall_issued", issued, 8'd6);

        // Pushes overlapping PH1-to-PH0 pops.
        step(1'b1, 8'hA1, 1'b1);
        step(1'b1, 8'hA2, 1'b1);
        step(1'b1, 8'hA3, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hA4, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        drain();

        // Reset during PH1 with operands queued.
        async_reset("rst_idle");
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b1);
        guard = 0;
        while (!(m_active && m_done_cycles == 1 && m_issued == 8'd2) && guard < 50) begin
            step(1'b1, 8'($urandom), 1'b0);
            guard++;
        end
        chk("ph1_reached", {31'd0, m_active && m_done_cycles == 1}, 32'd1);
        async_reset("rst_ph1");
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
        chk("post_rst_issued", issued, 8'd0);
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_first_x", x, 8'h3C);
        drain();

        // Randomized traffic with random stalls.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 25));
        end
        drain();

        // 257 operands of 0xFF from a fresh reset: issued wraps to 1.
        async_reset("rst_wrap");
        accepted = 0;
        guard = 0;
        while (accepted < 257 && guard < 2000) begin
            if (m_q.size() != DEPTH) accepted++;
            step(1'b1, 8'hFF, 1'b0);
            guard++;
        end
        drain();
        chk("wrap_issued", issued, 8'd1);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
